// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock with a
// start/busy/done handshake. Results hold until the next accepted start.
module seq_restoring_divider #(
  parameter int unsigned DIVIDEND_W = 8,
  parameter int unsigned DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int unsigned CNT_W = $clog2(DIVIDEND_W + 1);
  localparam int unsigned REM_W = DIVISOR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DIVIDEND_W-1:0] r_shift;
  logic [REM_W-1:0]      r_prem;
  logic [DIVISOR_W-1:0]  r_divisor;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic [DIVIDEND_W-1:0] r_quotient;
  logic [DIVISOR_W-1:0]  r_remainder;
  logic                  r_div_by_zero;

  logic [REM_W:0]        w_shifted;
  logic [REM_W-1:0]      w_trial;
  logic                  w_ok;
  logic                  w_calc_end;

  // Trial subtraction on the partial remainder shifted left by one dividend bit
  assign w_shifted  = {r_prem, r_shift[DIVIDEND_W-1]};
  assign w_ok       = (w_shifted >= (REM_W + 1)'(r_divisor));
  assign w_trial    = REM_W'(w_shifted - (REM_W + 1)'(r_divisor));
  assign w_calc_end = (r_divisor == '0) || (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_CALC;
      S_CALC:  if (w_calc_end) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered outputs; a zero divisor skips the iterations
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift       <= '0;
      r_prem        <= '0;
      r_divisor     <= '0;
      r_cnt         <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= (w_state_nxt == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shift       <= dividend;
            r_divisor     <= divisor;
            r_prem        <= '0;
            r_cnt         <= CNT_W'(DIVIDEND_W);
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
          end
        end
        S_CALC: begin
          if (r_divisor == '0) begin
            r_quotient    <= '1;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b1;
          end else if (r_cnt != '0) begin
            r_prem  <= w_ok ? w_trial : w_shifted[REM_W-1:0];
            r_shift <= {r_shift[DIVIDEND_W-2:0], w_ok};
            r_cnt   <= r_cnt - CNT_W'(1);
          end else begin
            r_quotient    <= r_shift;
            r_remainder   <= r_prem[DIVISOR_W-1:0];
            r_div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: directed vectors with literal expectations,
// a cycle-level behavioural model compared every cycle, and an operand sweep.
module tb_seq_restoring_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int n_checks = 0;
  int n_err    = 0;

  seq_restoring_divider #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an accepted division finishes a fixed number of edges later
  int unsigned m_busy, m_done, m_q, m_r, m_z, m_left, m_a, m_b;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_q = 0; m_r = 0; m_z = 0; m_left = 0;
    end
    chk("model_busy", busy, m_busy);
    chk("model_done", done, m_done);
    chk("model_quotient", quotient, m_q);
    chk("model_remainder", remainder, m_r);
    chk("model_div_by_zero", div_by_zero, m_z);
    if (rst_n) begin
      if (m_done != 0) begin
        m_done = 0;
        m_busy = 0;
      end else if (m_busy != 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1;
          if (m_b == 0) begin
            m_q = 255; m_r = 0; m_z = 1;
          end else begin
            m_q = m_a / m_b; m_r = m_a % m_b; m_z = 0;
          end
        end
      end else if (start) begin
        m_busy = 1;
        m_q = 0; m_r = 0; m_z = 0;
        m_a = dividend;
        m_b = divisor;
        m_left = (divisor == 0) ? 1 : 9;
      end
    end
  end

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!done && cyc < 30);
    chk("done_seen", done, 1);
  endtask

  task automatic launch(input int unsigned a, input int unsigned b);
    @(posedge clk); #1;
    start = 1'b1; dividend = 8'(a); divisor = 4'(b);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_div(input int unsigned a, input int unsigned b, input int unsigned eq,
                         input int unsigned er, input int unsigned ez, input int unsigned elat);
    int cyc;
    launch(a, b);
    chk("busy_after_accept", busy, 1);
    wait_done(cyc);
    chk("latency", cyc, elat);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_by_zero", div_by_zero, ez);
    @(posedge clk); #1;
    chk("busy_after_done", busy, 0);
    chk("done_after_done", done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int n_done;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_quotient", quotient, 0);
    rst_n = 1'b1;

    run_div(60, 3, 20, 0, 0, 9);
    run_div(208, 13, 16, 0, 0, 9);
    run_div(255, 10, 25, 5, 0, 9);
    run_div(242, 11, 22, 0, 0, 9);
    run_div(100, 7, 14, 2, 0, 9);
    run_div(3, 15, 0, 3, 0, 9);
    run_div(255, 1, 255, 0, 0, 9);
    run_div(5, 0, 255, 0, 1, 1);
    run_div(20, 4, 5, 0, 0, 9);

    // start pulsed with new operands mid-calculation must be ignored
    launch(60, 3);
    dividend = 8'd11; divisor = 4'd2;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; dividend = 8'd200; divisor = 4'd9;
    @(posedge clk); #1;
    start = 1'b0; dividend = 8'd77; divisor = 4'd5;
    wait_done(cyc);
    chk("ignored_start_latency", cyc + 4, 9);
    chk("ignored_start_quotient", quotient, 20);
    chk("ignored_start_remainder", remainder, 0);
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i == 0) chk("ignored_start_busy_low", busy, 0);
      if (done) n_done++;
    end
    chk("ignored_start_extra_done", n_done, 0);

    // asynchronous reset in the 4th CALC cycle
    launch(60, 3);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_quotient", quotient, 0);
    chk("async_rst_remainder", remainder, 0);
    chk("async_rst_dbz", div_by_zero, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    chk("done_after_abort", n_done, 0);
    run_div(100, 7, 14, 2, 0, 9);

    // sweep of every nonzero-divisor operand pair
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        launch(a, b);
        wait_done(cyc);
        chk("sweep_identity", quotient * b + remainder, a);
        chk("sweep_rem_lt_div", (remainder < b) ? 1 : 0, 1);
        @(posedge clk); #1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
